// File: rtl/bit_scan_32.sv
`default_nettype none
// ============================================================================
//  Module      : bit_scan_32
//  Description : Sequential set-bit enumerator. Accepts one WIDTH-bit word over
//                a valid/ready handshake and emits the index of every set bit,
//                one per cycle, over a valid/ready output stream. An all-zero
//                word produces a single beat flagged with zero=1.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                in_valid/in_ready/A          - input word handshake
//                out_valid/out_ready          - output beat handshake
//                idx   - index of current set bit
//                last  - current beat is the final beat of this word
//                zero  - accepted word was all-zero (single beat, idx=0)
//                cnt   - popcount of accepted word, held for the whole scan
//  Options     : `define BIT_SCAN_MSB_FIRST_EN to emit indices highest-first
//                (descending). Default build emits lowest-first (ascending).
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_scan_32 #(
    parameter int WIDTH = 32,   // must equal 2**IDXW
    parameter int IDXW  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDXW-1:0]  idx,
    output logic             last,
    output logic             zero,
    output logic [IDXW:0]    cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_EMPTY = 2'd2
    } state_t;

    state_t            state_q,     state_d;
    logic [WIDTH-1:0]  mask_q,      mask_d;
    logic              in_ready_q,  in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [IDXW-1:0]   idx_q,       idx_d;
    logic              last_q,      last_d;
    logic              zero_q,      zero_d;
    logic [IDXW:0]     cnt_q,       cnt_d;

    // Mask with the bit currently being emitted removed.
    logic [WIDTH-1:0]  w_mask_next;

    // Priority encoder over a mask; the scan direction is a build option.
    function automatic logic [IDXW-1:0] f_encode(input logic [WIDTH-1:0] m);
        logic [IDXW-1:0] r;
        r = '0;
`ifdef BIT_SCAN_MSB_FIRST_EN
        // Ascending loop: the highest set bit is written last and wins.
        for (int i = 0; i < WIDTH; i++) begin
            if (m[i]) r = IDXW'(i);
        end
`else
        // Descending loop: the lowest set bit is written last and wins.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (m[i]) r = IDXW'(i);
        end
`endif
        return r;
    endfunction

    function automatic logic [IDXW:0] f_popcount(input logic [WIDTH-1:0] m);
        logic [IDXW:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + (IDXW+1)'(m[i]);
        end
        return c;
    endfunction

    // True when exactly one bit of the mask is set.
    function automatic logic f_onehot(input logic [WIDTH-1:0] m);
        return (m != '0) && ((m & (m - WIDTH'(1))) == '0);
    endfunction

    assign w_mask_next = mask_q & ~(WIDTH'(1) << idx_q);

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        idx_d       = idx_q;
        last_d      = last_q;
        zero_d      = zero_q;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE: begin
                // in_ready is 1 throughout IDLE, so in_valid alone accepts.
                if (in_valid) begin
                    mask_d      = A;
                    cnt_d       = f_popcount(A);
                    in_ready_d  = 1'b0;
                    out_valid_d = 1'b1;
                    if (A == '0) begin
                        state_d = ST_EMPTY;
                        idx_d   = '0;
                        last_d  = 1'b1;
                        zero_d  = 1'b1;
                    end else begin
                        state_d = ST_SCAN;
                        idx_d   = f_encode(A);
                        last_d  = f_onehot(A);
                        zero_d  = 1'b0;
                    end
                end
            end

            ST_SCAN: begin
                if (out_ready) begin
                    mask_d = w_mask_next;
                    if (last_q) begin
                        // cnt is deliberately held until the next accept.
                        state_d     = ST_IDLE;
                        in_ready_d  = 1'b1;
                        out_valid_d = 1'b0;
                        idx_d       = '0;
                        last_d      = 1'b0;
                        zero_d      = 1'b0;
                    end else begin
                        idx_d  = f_encode(w_mask_next);
                        last_d = f_onehot(w_mask_next);
                    end
                end
            end

            ST_EMPTY: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                    idx_d       = '0;
                    last_d      = 1'b0;
                    zero_d      = 1'b0;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                mask_d      = '0;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                idx_d       = '0;
                last_d      = 1'b0;
                zero_d      = 1'b0;
                cnt_d       = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            idx_q       <= '0;
            last_q      <= 1'b0;
            zero_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            zero_q      <= zero_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign idx       = idx_q;
    assign last      = last_q;
    assign zero      = zero_q;
    assign cnt       = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bit_scan_32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bit_scan_32
//  Description : Directed self-checking bench for bit_scan_32. Expected index
//                sequences follow BIT_SCAN_MSB_FIRST_EN when it is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_scan_32;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  idx;
    logic        last;
    logic        zero;
    logic [5:0]  cnt;

    int errors = 0;
    int checks = 0;

    bit_scan_32 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .idx       (idx),
        .last      (last),
        .zero      (zero),
        .cnt       (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: presents the word for one posedge, returns at the
    // following negedge with the first beat visible.
    task automatic accept(input logic [31:0] w);
        in_valid = 1'b1;
        A        = w;
        @(negedge clk);
        in_valid = 1'b0;
        A        = '0;
    endtask

    initial begin
        int seq7b [6];
        int exp_i;
`ifdef BIT_SCAN_MSB_FIRST_EN
        seq7b = '{6, 5, 4, 3, 1, 0};
`else
        seq7b = '{0, 1, 3, 4, 5, 6};
`endif
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_valid", out_valid, 0);
        check("rst_idx",       idx,       0);
        check("rst_last",      last,      0);
        check("rst_zero",      zero,      0);
        check("rst_cnt",       cnt,       0);

        // All-zero word -> single EMPTY beat
        accept(32'h0000_0000);
        check("z_out_valid", out_valid, 1);
        check("z_in_ready",  in_ready,  0);
        check("z_zero",      zero,      1);
        check("z_last",      last,      1);
        check("z_idx",       idx,       0);
        check("z_cnt",       cnt,       0);
        out_ready = 1'b1;
        @(negedge clk);
        check("z_done_out_valid", out_valid, 0);
        check("z_done_in_ready",  in_ready,  1);
        out_ready = 1'b0;

        // 0x7B: six beats back to back
        accept(32'h0000_007B);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check("7b_out_valid", out_valid, 1);
            check("7b_idx",       idx,       seq7b[k]);
            check("7b_last",      last,      (k == 5));
            check("7b_zero",      zero,      0);
            check("7b_cnt",       cnt,       6);
            @(negedge clk);
        end
        check("7b_done_out_valid", out_valid, 0);
        check("7b_done_in_ready",  in_ready,  1);
        check("7b_cnt_held",       cnt,       6);
        out_ready = 1'b0;

        // 0x80000001 with out_ready 1,0,0,1
        accept(32'h8000_0001);
        out_ready = 1'b1;
`ifdef BIT_SCAN_MSB_FIRST_EN
        exp_i = 31;
`else
        exp_i = 0;
`endif
        check("b31_first_idx",  idx,  exp_i);
        check("b31_first_last", last, 0);
        check("b31_cnt",        cnt,  2);
        @(negedge clk);
        out_ready = 1'b0;
        exp_i = 31 - exp_i;
        for (int s = 0; s < 3; s++) begin
            check("b31_second_valid", out_valid, 1);
            check("b31_second_idx",   idx,       exp_i);
            check("b31_second_last",  last,      1);
            if (s < 2) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("b31_done_out_valid", out_valid, 0);
        check("b31_done_in_ready",  in_ready,  1);
        out_ready = 1'b0;

        // 0xFFFFFFFF: 32 beats; a mid-scan in_valid with A=4 must be ignored
        accept(32'hFFFF_FFFF);
        out_ready = 1'b1;
        for (int k = 0; k < 32; k++) begin
`ifdef BIT_SCAN_MSB_FIRST_EN
            exp_i = 31 - k;
`else
            exp_i = k;
`endif
            check("ff_out_valid", out_valid, 1);
            check("ff_idx",       idx,       exp_i);
            check("ff_last",      last,      (k == 31));
            check("ff_cnt",       cnt,       32);
            if (k == 10) begin
                in_valid = 1'b1;
                A        = 32'h0000_0004;
            end else if (k == 11) begin
                in_valid = 1'b0;
                A        = '0;
            end
            @(negedge clk);
        end
        check("ff_done_out_valid", out_valid, 0);
        check("ff_done_in_ready",  in_ready,  1);
        @(negedge clk);
        check("ff_no_extra_beat", out_valid, 0);
        out_ready = 1'b0;

        // Reset mid-scan while stalled
        accept(32'h0000_0004);
        check("r_out_valid", out_valid, 1);
        check("r_idx",       idx,       2);
        check("r_last",      last,      1);
        check("r_cnt",       cnt,       1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("r_after_out_valid", out_valid, 0);
        check("r_after_in_ready",  in_ready,  1);
        check("r_after_cnt",       cnt,       0);
        check("r_after_idx",       idx,       0);
        @(negedge clk);
        check("r_idle_out_valid", out_valid, 0);

        accept(32'h0000_0002);
        out_ready = 1'b1;
        check("two_out_valid", out_valid, 1);
        check("two_idx",       idx,       1);
        check("two_last",      last,      1);
        check("two_cnt",       cnt,       1);
        check("two_zero",      zero,      0);
        @(negedge clk);
        check("two_done_out_valid", out_valid, 0);
        check("two_done_in_ready",  in_ready,  1);
        out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
